toggle_activity_counter: RTL and testbench

Switching-activity accumulator that sits directly downstream of the gate-level blocks under power analysis, such as the 2:1 mux. It samples a vector of monitored nets, for example the mux's a, b, sel and out, over a programmable window of valid samples. It counts 0↔1 transitions per net and returns per-net and total toggle counts through a valid/ready result port. Downstream power-weighting logic consumes these counts.

---
 rtl/toggle_activity_counter.sv | 144 ++++++++++++++
 tb/tb_toggle_activity_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/toggle_activity_counter.sv
// Switching-activity accumulator: counts 0<->1 transitions per monitored net
// over a window of valid samples and reports per-net and total counts.
module toggle_activity_counter #(
    parameter int NUM_NETS = 4,
    parameter int CNT_W    = 16,
    parameter int WIN_W    = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [WIN_W-1:0]                      win_len,
    input  logic                                  sample_valid,
    input  logic [NUM_NETS-1:0]                   sample,
    output logic                                  busy,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [NUM_NETS*CNT_W-1:0]             res_toggles,
    output logic [CNT_W+$clog2(NUM_NETS)-1:0]     res_total,
    output logic                                  res_overflow
);

    localparam int TOT_W = CNT_W + $clog2(NUM_NETS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  busy_r;
    logic                  res_valid_r;
    logic [WIN_W-1:0]      win_len_r;
    logic [WIN_W-1:0]      seen_r;
    logic [NUM_NETS-1:0]   prev_r;
    logic                  have_prev_r;
    logic [CNT_W-1:0]      cnt_r [NUM_NETS];
    logic [CNT_W-1:0]      cnt_s [NUM_NETS];
    logic                  ovf_r;
    logic                  ovf_hit_s;
    logic [TOT_W-1:0]      total_r;
    logic [TOT_W-1:0]      sum_s;
    logic                  start_ok_s;
    logic                  accept_s;

    assign start_ok_s = (state_r == IDLE) && start && (win_len != '0);
    // Once seen reaches win_len, the COUNT cycle only hands over to REPORT.
    assign accept_s   = (state_r == COUNT) && sample_valid && (seen_r != win_len_r);

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) state_s = COUNT;
                else            state_s = IDLE;
            end
            COUNT: begin
                if (seen_r == win_len_r) state_s = REPORT;
                else                     state_s = COUNT;
            end
            REPORT: begin
                if (res_ready) state_s = IDLE;
                else           state_s = REPORT;
            end
            default: state_s = IDLE;
        endcase
    end

    // Saturating per-net toggle increments for the current sample
    always_comb begin
        ovf_hit_s = 1'b0;
        for (int i = 0; i < NUM_NETS; i++) begin
            cnt_s[i] = cnt_r[i];
            if (have_prev_r && (sample[i] ^ prev_r[i])) begin
                if (cnt_r[i] == {CNT_W{1'b1}}) begin
                    ovf_hit_s = 1'b1;
                end else begin
                    cnt_s[i] = cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                cnt_s[i] = cnt_r[i];
            end
        end
    end

    // Total of the saturated per-net counts
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < NUM_NETS; i++) begin
            sum_s = sum_s + TOT_W'(cnt_r[i]);
        end
    end

    // State, window bookkeeping and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            win_len_r   <= '0;
            seen_r      <= '0;
            prev_r      <= '0;
            have_prev_r <= 1'b0;
            ovf_r       <= 1'b0;
            total_r     <= '0;
            for (int i = 0; i < NUM_NETS; i++) cnt_r[i] <= '0;
        end else begin
            state_r     <= state_s;
            busy_r      <= (state_s != IDLE);
            res_valid_r <= (state_s == REPORT);
            if (start_ok_s) begin
                win_len_r   <= win_len;
                seen_r      <= '0;
                prev_r      <= '0;
                have_prev_r <= 1'b0;
                ovf_r       <= 1'b0;
                total_r     <= '0;
                for (int i = 0; i < NUM_NETS; i++) cnt_r[i] <= '0;
            end else if (accept_s) begin
                for (int i = 0; i < NUM_NETS; i++) cnt_r[i] <= cnt_s[i];
                ovf_r       <= ovf_r | ovf_hit_s;
                prev_r      <= sample;
                have_prev_r <= 1'b1;
                seen_r      <= seen_r + {{(WIN_W-1){1'b0}}, 1'b1};
            end else if ((state_r == COUNT) && (state_s == REPORT)) begin
                total_r <= sum_s;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_NETS; g++) begin : g_pack
            assign res_toggles[g*CNT_W +: CNT_W] = cnt_r[g];
        end
    endgenerate

    assign busy         = busy_r;
    assign res_valid    = res_valid_r;
    assign res_total    = total_r;
    assign res_overflow = ovf_r;

endmodule

// File: tb/tb_toggle_activity_counter.sv
// Directed bench for toggle_activity_counter: a default-width instance plus a
// CNT_W=4 instance sharing the same stimulus to exercise saturation.
module tb_toggle_activity_counter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] win_len;
    logic        sample_valid;
    logic [3:0]  sample;
    logic        res_ready;

    logic        busy, res_valid, res_overflow;
    logic [63:0] res_toggles;
    logic [17:0] res_total;

    logic        busy4, res_valid4, res_overflow4;
    logic [15:0] res_toggles4;
    logic [5:0]  res_total4;

    int n_total = 0;
    int n_bad   = 0;

    // {out,sel,b,a} for the mux vectors a,b,sel,out = 0100,1010,1001,1111,0010,1111,1001
    logic [3:0] mux_v [7] = '{4'b0010, 4'b0101, 4'b1001, 4'b1111, 4'b0100, 4'b1111, 4'b1001};
    localparam logic [63:0] MUX_TOG = 64'h0003_0004_0005_0003;

    toggle_activity_counter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
        .sample_valid(sample_valid), .sample(sample), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_toggles(res_toggles),
        .res_total(res_total), .res_overflow(res_overflow)
    );

    toggle_activity_counter #(.NUM_NETS(4), .CNT_W(4), .WIN_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
        .sample_valid(sample_valid), .sample(sample), .busy(busy4),
        .res_valid(res_valid4), .res_ready(res_ready), .res_toggles(res_toggles4),
        .res_total(res_total4), .res_overflow(res_overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] n);
        @(negedge clk);
        start   = 1'b1;
        win_len = n;
        @(negedge clk);
        start   = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic feed(input logic [3:0] v, input int gap);
        sample_valid = 1'b1;
        sample       = v;
        @(negedge clk);
        for (int g = 0; g < gap; g++) begin
            sample_valid = 1'b0;
            sample       = 4'($urandom);
            @(negedge clk);
        end
        sample_valid = 1'b0;
    endtask

    task automatic mux_window(input string tag, input int gap);
        do_start(16'd7);
        for (int i = 0; i < 7; i++) feed(mux_v[i], (i == 6) ? 0 : gap);
        check({tag, "_rv_early"}, {63'd0, res_valid}, 64'd0);
        @(negedge clk);
        check({tag, "_rv"},    {63'd0, res_valid}, 64'd1);
        check({tag, "_tog"},   res_toggles, MUX_TOG);
        check({tag, "_total"}, {46'd0, res_total}, 64'd15);
        check({tag, "_ovf"},   {63'd0, res_overflow}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; win_len = 16'd0;
        sample_valid = 1'b0; sample = 4'd0; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy",  {63'd0, busy}, 64'd0);
        check("rst_rv",    {63'd0, res_valid}, 64'd0);
        check("rst_tog",   res_toggles, 64'd0);
        check("rst_total", {46'd0, res_total}, 64'd0);
        check("rst_ovf",   {63'd0, res_overflow}, 64'd0);
        rst_n = 1'b1;

        // Back-to-back mux window, res_ready held high
        mux_window("mux", 0);
        @(negedge clk);
        check("mux_rv_drop", {63'd0, res_valid}, 64'd0);
        check("mux_idle",    {63'd0, busy}, 64'd0);
        check("mux_hold_idle", {46'd0, res_total}, 64'd15);

        // Gapped window, then backpressure in REPORT
        res_ready = 1'b0;
        mux_window("gap", 3);
        for (int c = 0; c < 5; c++) begin
            start = 1'b1; win_len = 16'd3;
            sample_valid = 1'b1; sample = 4'($urandom);
            @(negedge clk);
            check("bp_rv",    {63'd0, res_valid}, 64'd1);
            check("bp_busy",  {63'd0, busy}, 64'd1);
            check("bp_tog",   res_toggles, MUX_TOG);
            check("bp_total", {46'd0, res_total}, 64'd15);
        end
        start = 1'b0; sample_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_busy", {63'd0, busy}, 64'd0);
        check("bp_release_rv",   {63'd0, res_valid}, 64'd0);

        // Reset mid-window after 3 of 7 samples
        do_start(16'd7);
        for (int i = 0; i < 3; i++) feed(mux_v[i], 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  {63'd0, busy}, 64'd0);
        check("mid_rst_rv",    {63'd0, res_valid}, 64'd0);
        check("mid_rst_tog",   res_toggles, 64'd0);
        check("mid_rst_total", {46'd0, res_total}, 64'd0);
        check("mid_rst_ovf",   {63'd0, res_overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mux_window("post_rst", 0);

        // Saturation: 20 samples, bit0 alternating, others constant
        do_start(16'd20);
        for (int i = 0; i < 20; i++) feed({3'b101, 1'(i % 2)}, 0);
        @(negedge clk);
        check("sat_rv",      {63'd0, res_valid4}, 64'd1);
        check("sat_tog4",    {48'd0, res_toggles4}, 64'h000F);
        check("sat_total4",  {58'd0, res_total4}, 64'd15);
        check("sat_ovf4",    {63'd0, res_overflow4}, 64'd1);
        check("wide_tog",    res_toggles, 64'h0000_0000_0000_0013);
        check("wide_total",  {46'd0, res_total}, 64'd19);
        check("wide_ovf",    {63'd0, res_overflow}, 64'd0);
        @(negedge clk);

        // win_len=0 is ignored
        start = 1'b1; win_len = 16'd0;
        @(negedge clk);
        start = 1'b0;
        check("len0_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("len0_busy2", {63'd0, busy}, 64'd0);

        // win_len=1; the sample in the start cycle must not count
        start = 1'b1; win_len = 16'd1; sample_valid = 1'b1; sample = 4'hF;
        @(negedge clk);
        start = 1'b0; sample = 4'h0;
        @(negedge clk);
        sample_valid = 1'b0;
        check("len1_rv_early", {63'd0, res_valid}, 64'd0);
        @(negedge clk);
        check("len1_rv",    {63'd0, res_valid}, 64'd1);
        check("len1_tog",   res_toggles, 64'd0);
        check("len1_total", {46'd0, res_total}, 64'd0);
        check("len1_ovf",   {63'd0, res_overflow}, 64'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
